tt_vector_sequencer: RTL
========================

Name: tt_vector_sequencer

Overview:
Parametrised on-chip stimulus/response sequencer for the digiOTA Tiny Tapeout project. It plays a programmed table of input vectors into the user design and samples its outputs after a programmable settle time. Each response is compared, under a mask, against an expected value, and the block reports pass/fail, an error count and the first failing index. It sits between the top-level IO pins and the DUT core, so the bench or host can run it once or in a continuous loop.

Parameters:
DATA_W, 8, width of stimulus, response, expected and mask words
DEPTH, 16, vector table entries (power of two, 2..256)
AW, $clog2(DEPTH), table address width (derived)
SETTLE_W, 4, width of the settle-cycle counter
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  table write strobe (ignored while busy)
cfg_addr  in  AW  table write address
cfg_stim  in  DATA_W  stimulus word to store
cfg_exp  in  DATA_W  expected response word
cfg_mask  in  DATA_W  compare mask (1 = bit checked)
last_idx  in  AW  index of last vector to run (run covers 0..last_idx)
settle  in  SETTLE_W  wait cycles between drive and sample
loop_mode  in  1  0 = single pass, 1 = repeat until abort
start  in  1  one-cycle run request
abort  in  1  stop run
stim_out  out  DATA_W  registered stimulus to DUT
resp_in  in  DATA_W  DUT response
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of pass/abort
pass  out  1  sticky: last completed run had zero errors
err_cnt  out  CNT_W  mismatches in current/last run, saturating
first_err_idx  out  AW  index of first mismatch
first_err_valid  out  1  first_err_idx holds a value

Behaviour:
- Reset (clk edge with rst=1):
  - stim_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, first_err_valid=0, FSM=IDLE.
  - Table contents are not reset.
- Table: DEPTH x (stim, exp, mask) registers. Written when cfg_we=1 and FSM=IDLE; writes in any other state are dropped.
- FSM states:
  - IDLE: start=1 -> DRIVE, with idx=0, err_cnt=0, first_err_valid=0, busy=1.
  - DRIVE (1 cycle): stim_out<=stim[idx]; wait counter loads settle. Next state is WAIT if settle>0, else SAMPLE.
  - WAIT: decrement the counter; go to SAMPLE when it reaches 1.
  - SAMPLE (1 cycle): mismatch = ((resp_in ^ exp[idx]) & mask[idx]) != 0.
    - On mismatch: err_cnt increments, saturating at 2^CNT_W-1. If first_err_valid=0, capture first_err_idx=idx and set first_err_valid=1.
    - If idx<last_idx: idx++ and go to DRIVE.
    - Else (end of pass): pulse done=1 for 1 cycle and set pass=(err_cnt after this sample == 0).
      - loop_mode=1: idx=0 and go to DRIVE. err_cnt and first_err persist across passes; pass updates every pass.
      - loop_mode=0: go to IDLE with busy=0.
- Timing: each vector takes settle+2 cycles. stim_out is stable for settle+1 cycles before resp_in is sampled. stim_out holds its last value after the run ends.
- abort=1 in any non-IDLE state:
  - Next cycle the FSM is IDLE, busy=0 and done pulses.
  - pass is forced to 0.
  - err_cnt and first_err keep their values.
  - abort has priority over a same-cycle SAMPLE result: that sample is discarded.
- start while busy is ignored. start and abort together in IDLE: abort wins, nothing starts and no done pulse.
- last_idx, settle and loop_mode are sampled live. Changing them mid-run is allowed and takes effect at the next DRIVE.
- last_idx=0: single-vector run.
- rst mid-run returns to the reset state on that edge; no done pulse.

Test Plan:
- Load DEPTH=16 table with stim=i, exp=i^8'h5A, mask=8'hFF; DUT model resp=stim^8'h5A; last_idx=15, settle=2, single pass -> done pulses exactly 64 cycles after start, pass=1, err_cnt=0, first_err_valid=0.
- Same table with DUT error at vectors 3 and 9 (resp bit0 flipped) -> err_cnt=2, first_err_idx=3, pass=0. Repeat with mask[3]=8'hFE -> err_cnt=1, first_err_idx=9.
- settle=0, last_idx=0, single vector -> stim_out updates 1 cycle after start, sample on the next cycle, done 2 cycles after start.
- loop_mode=1 with one persistent error, CNT_W=8, 300 passes -> done pulses once per pass, err_cnt saturates at 255, pass stays 0; abort -> busy=0 next cycle and one done pulse.
- cfg_we while busy targeting addr 0 -> the table is unchanged on the next run; start while busy has no effect on idx.
- Assert rst during WAIT -> next cycle busy=0, stim_out=0, err_cnt=0, no done pulse; a new start runs normally from idx 0.

Source files
------------

// File: rtl/tt_vector_sequencer.sv
// Vector table sequencer: plays stored stimulus into the user design, waits a settle
// time, then compares the masked response against the expected word and tallies errors.
module tt_vector_sequencer #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int SETTLE_W = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [DATA_W-1:0]   cfg_stim,
    input  logic [DATA_W-1:0]   cfg_exp,
    input  logic [DATA_W-1:0]   cfg_mask,
    input  logic [AW-1:0]       last_idx,
    input  logic [SETTLE_W-1:0] settle,
    input  logic                loop_mode,
    input  logic                start,
    input  logic                abort,
    output logic [DATA_W-1:0]   stim_out,
    input  logic [DATA_W-1:0]   resp_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [AW-1:0]       first_err_idx,
    output logic                first_err_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE
    } state_t;

    state_t state, state_next;

    logic [AW-1:0]       idx;
    logic [SETTLE_W-1:0] wait_cnt;
    logic [DATA_W-1:0]   stim_mem [DEPTH];
    logic [DATA_W-1:0]   exp_mem  [DEPTH];
    logic [DATA_W-1:0]   mask_mem [DEPTH];

    logic                mismatch;
    logic                end_of_pass;
    logic                abort_run;
    logic [CNT_W-1:0]    err_cnt_upd;

    // Table has no reset; it can only be rewritten while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE) begin
            stim_mem[cfg_addr] <= cfg_stim;
            exp_mem[cfg_addr]  <= cfg_exp;
            mask_mem[cfg_addr] <= cfg_mask;
        end
    end

    always_comb begin
        state_next  = state;
        abort_run   = abort && (state != S_IDLE);
        mismatch    = ((resp_in ^ exp_mem[idx]) & mask_mem[idx]) != '0;
        end_of_pass = (idx >= last_idx);
        err_cnt_upd = err_cnt;
        if (mismatch && err_cnt != {CNT_W{1'b1}}) begin
            err_cnt_upd = err_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_next = (settle != '0) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                if (wait_cnt <= 1) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_next = (end_of_pass && !loop_mode) ? S_IDLE : S_DRIVE;
            end
            default: state_next = S_IDLE;
        endcase

        // Abort outranks everything, including the result of a sample in flight.
        if (abort_run) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            idx             <= '0;
            wait_cnt        <= '0;
            stim_out        <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (abort_run) begin
                done <= 1'b1;
                pass <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            idx             <= '0;
                            err_cnt         <= '0;
                            first_err_valid <= 1'b0;
                        end
                    end
                    S_DRIVE: begin
                        stim_out <= stim_mem[idx];
                        wait_cnt <= settle;
                    end
                    S_WAIT: begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                    S_SAMPLE: begin
                        err_cnt <= err_cnt_upd;
                        if (mismatch && !first_err_valid) begin
                            first_err_idx   <= idx;
                            first_err_valid <= 1'b1;
                        end
                        if (end_of_pass) begin
                            done <= 1'b1;
                            pass <= (err_cnt_upd == '0);
                            idx  <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
